uart_frame_check: RTL
=====================

# uart_frame_check

Parametrised receive-side frame checker for the UART receiver. It consumes the sampled serial bit stream one bit per `bit_valid` strobe and tracks frame position with a state machine. It checks data parity (none/even/odd/mark) and stop-bit framing, and reports per-frame results with a completion pulse. It sits between the RX bit sampler and the RX data register/status logic, and supersedes the single-flag parity checker.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame (5..9)
- `STOP_BITS`, 1, stop bits checked per frame (1..2)
- `CNT_W`, 8, width of the error counter

Ports:
- `clk` input 1: system clock; everything is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `frame_start` input 1: one-cycle pulse from the sampler when a valid start bit is detected.
- `bit_valid` input 1: one-cycle strobe; `serial_in` holds a sampled bit this cycle.
- `serial_in` input 1: sampled line bit.
- `parity_mode` input 2: 00 none, 01 even, 10 odd, 11 mark (parity bit must be 1). Sampled at `frame_start`.
- `clear_count` input 1: synchronous clear of `err_count`.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse; frame completed.
- `parity_err` output 1: 1 means the last frame had a parity mismatch.
- `frame_err` output 1: 1 means the last frame had a stop bit at 0.
- `err_count` output CNT_W: saturating count of frames with any error.

## Operation
- States:
  - IDLE: waits for `frame_start`.
  - DATA: counts data bits.
  - PARITY: checks the parity bit.
  - STOP: checks stop bits.
- IDLE→DATA on `frame_start`:
  - Clear the bit counter and the XOR accumulator.
  - Latch `parity_mode`.
  - Clear `parity_err` and `frame_err`.
- DATA: on each `bit_valid`, `acc <= acc ^ serial_in` and the counter increments. On the `DATA_BITS`-th bit, go to PARITY if the latched mode is not 00, else go to STOP.
- PARITY: on `bit_valid`, compare `serial_in` against the expected parity bit, then go to STOP.
  - Expected bit: even = `acc`, odd = `~acc`, mark = 1.
  - A mismatch sets an internal parity flag.
- STOP: on each `bit_valid`, a `serial_in` of 0 sets an internal framing flag.
- After the `STOP_BITS`-th stop bit:
  - Go to IDLE.
  - Pulse `done`.
  - Load `parity_err` and `frame_err` from the internal flags.
- `parity_err` and `frame_err` hold until the next `frame_start`. `parity_err` is always 0 in mode 00.
- `frame_start` while busy aborts the current frame: restart in DATA with no `done` and no counter update.
- `frame_start` and `bit_valid` in the same cycle: `frame_start` wins and the bit is ignored (it is the start bit).
- `bit_valid` in IDLE is ignored.
- `busy` = state is not IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `parity_err`, `frame_err` = 0.
  - `err_count` = 0.
  - Accumulator and counters = 0.
- `busy` rises the cycle after `frame_start`.
- `done`, `parity_err` and `frame_err` update the cycle after the last stop-bit `bit_valid`. `busy` falls in that same cycle.
- `err_count` increments in the same cycle `done` rises, if either error is set. It saturates at 2^CNT_W−1.
- `clear_count` zeroes `err_count` the next cycle. If a clear and an increment coincide, clear wins (result 0).
- Reset mid-frame returns to IDLE immediately, with no `done`.
- There is no minimum spacing between `bit_valid` strobes. Back-to-back strobes on consecutive cycles are legal.
- A new `frame_start` is legal in the cycle `done` is asserted.

## Configuration
- `UART_ERR_COUNT_EN` defined:
  - The `err_count` register and `clear_count` logic are built as described.
- `UART_ERR_COUNT_EN` undefined:
  - `err_count` is tied to 0.
  - `clear_count` is ignored.
  - No counter flops are generated.
  - All other behaviour is identical.

## Test plan
- Even mode, DATA_BITS=8, data 0x55, parity bit 0, stop 1 → `done` pulse, `parity_err`=0, `frame_err`=0, `err_count`=0.
- Odd mode, data 0x01, parity bit 1 → `parity_err`=1 and `err_count`=1. Then a mark-mode frame with parity bit 1 and stop 1 → `parity_err`=0 and `err_count` stays 1.
- Mode none, STOP_BITS=2, data 0xA3, stops 1 then 0 → `frame_err`=1, `parity_err`=0, and `done` after exactly 10 strobes.
- `frame_start` after 4 data bits → no `done`. The next complete good frame yields a single `done` with both error flags at 0.
- With CNT_W=2, send 5 erroring frames → `err_count` saturates at 3. Assert `clear_count` in the same cycle as a 6th erroring frame's `done` → `err_count`=0.
- Assert `reset` mid-PARITY → `busy`, `done` and the flags go to 0 immediately. The next frame completes normally.

Source files
------------

// File: rtl/uart_frame_check.sv
// uart_frame_check
//
// Receive-side UART frame checker. Consumes the sampled serial bit stream one
// bit per bit_valid strobe, follows the frame position (data, optional parity,
// stop bits) and reports per-frame parity and framing errors together with a
// one-cycle completion pulse. It sits between the RX bit sampler and the RX
// data register/status logic.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   STOP_BITS  stop bits checked per frame (1..2)
//   CNT_W      width of the saturating error counter
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   frame_start  one-cycle pulse: start bit detected (also aborts a frame in progress)
//   bit_valid    one-cycle strobe: serial_in holds a sampled bit
//   serial_in    sampled line bit
//   parity_mode  00 none, 01 even, 10 odd, 11 mark; sampled at frame_start
//   clear_count  synchronous clear of err_count (wins over an increment)
//   busy         a frame is in progress
//   done         one-cycle pulse when a frame completes
//   parity_err   last frame had a parity mismatch (held until next frame_start)
//   frame_err    last frame had a stop bit at 0 (held until next frame_start)
//   err_count    saturating count of completed frames with any error
//
// Configuration macro:
//   UART_ERR_COUNT_EN  when defined, the err_count register and clear_count
//                      logic are built; otherwise err_count is tied to 0 and
//                      clear_count is ignored.

module uart_frame_check #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic [1:0]       parity_mode,
  input  logic             clear_count,
  output logic             busy,
  output logic             done,
  output logic             parity_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  // Bit counter wide enough for up to 9 data bits.
  localparam int BCW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           acc_q, acc_d;
  logic [1:0]     mode_q, mode_d;
  logic           par_flag_q, par_flag_d;
  logic           frm_flag_q, frm_flag_d;
  logic           done_q, done_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;
  logic           exp_par;
  logic           frame_end;

  // Next-state and datapath. frame_start has priority over everything else:
  // it both starts a fresh frame and aborts one in progress, and a bit_valid
  // arriving in the same cycle is the start bit itself, so it is dropped.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    par_flag_d   = par_flag_q;
    frm_flag_d   = frm_flag_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    done_d       = 1'b0;
    frame_end    = 1'b0;
    exp_par      = 1'b1;

    if (frame_start) begin
      state_d      = DATA;
      bit_cnt_d    = '0;
      acc_d        = 1'b0;
      mode_d       = parity_mode;
      par_flag_d   = 1'b0;
      frm_flag_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        DATA: begin
          acc_d = acc_q ^ serial_in;
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (mode_q != 2'b00) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          // acc holds the XOR of all data bits: even parity expects it
          // directly, odd its inverse, mark a constant 1.
          case (mode_q)
            2'b01:   exp_par = acc_q;
            2'b10:   exp_par = ~acc_q;
            default: exp_par = 1'b1;
          endcase
          if (serial_in != exp_par) begin
            par_flag_d = 1'b1;
          end
          state_d = STOP;
        end
        STOP: begin
          if (!serial_in) begin
            frm_flag_d = 1'b1;
          end
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            // The current stop bit is folded in directly so the reported
            // flags include it without waiting another cycle.
            state_d      = IDLE;
            bit_cnt_d    = '0;
            done_d       = 1'b1;
            frame_end    = 1'b1;
            parity_err_d = par_flag_q;
            frame_err_d  = frm_flag_q | ~serial_in;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      acc_q        <= 1'b0;
      mode_q       <= 2'b00;
      par_flag_q   <= 1'b0;
      frm_flag_q   <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      par_flag_q   <= par_flag_d;
      frm_flag_q   <= frm_flag_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

`ifdef UART_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Counts completed frames carrying any error; clear beats a coincident
  // increment and the count sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = '0;
    end else if (frame_end && (parity_err_d || frame_err_d) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_clear_count;

  assign unused_clear_count = clear_count;
  assign err_count          = '0;
`endif

endmodule
